cmd_sched: RTL
==============

Name: cmd_sched

Overview:
- Arbitrates and sequences launches of the command-encoder core (cmd_core) between three requesters:
  - external trigger (TRIG_REQ),
  - periodic auto-zero (internal timer),
  - software start (SW_REQ).
- Sits in CMD_CLK domain between trigger/TLU logic and cmd_core.
- Drives cmd_core start and sequence-select; generates the AZ veto window; counts dropped triggers.

Parameters:
- CNT_W, 16, width of dropped-trigger counter (saturating)
- TIMEOUT, 64, max cycles from START to CMD_BUSY rise before abort
- AZ_W, 16, width of AZ_PERIOD and internal AZ timer

Ports:
- CMD_CLK  in  1  sole clock
- CMD_RST_N  in  1  reset, asynchronous assert, active-low
- ENABLE  in  1  scheduler enable (level)
- AZ_PERIOD  in  AZ_W  cycles between AZ requests; 0 = AZ disabled
- VETO_LEN  in  8  trigger-veto extension after AZ sequence ends, cycles
- TRIG_REQ  in  1  trigger request, 1-cycle pulse
- SW_REQ  in  1  software start request, 1-cycle pulse
- CMD_BUSY  in  1  cmd_core CMD_WRITING
- CNT_CLR  in  1  synchronous clear of TRIG_DROP_CNT
- START  out  1  1-cycle launch pulse to cmd_core
- SEL  out  2  sequence select: 0 none, 1 trig, 2 AZ, 3 SW
- AZ_VETO_FLAG  out  1  triggers vetoed
- TIMEOUT_ERR  out  1  sticky; set on launch timeout, cleared by CNT_CLR
- TRIG_DROP_CNT  out  CNT_W  dropped-trigger count

Behaviour:
- Reset (CMD_RST_N=0, async): all outputs 0, all pending flags 0, AZ timer 0, state IDLE.
- Pending flags trig_p, az_p, sw_p, 1-deep each, set at the edge sampling the request.
- AZ timer:
  - Increments while ENABLE=1 and AZ_PERIOD!=0.
  - When timer == AZ_PERIOD-1: sets az_p, timer reloads 0.
  - AZ_PERIOD=1 → az_p requested every cycle.
  - An AZ_PERIOD change takes effect at the next compare; no reset of the timer.
- FSM states IDLE, WAIT_BUSY, RUN, VETO:
  - IDLE:
    - If ENABLE=1, any flag pending, and CMD_BUSY=0: grant highest priority (trig > AZ > SW).
    - On grant: START=1 for exactly that cycle, SEL registered, granted flag cleared, go WAIT_BUSY.
    - Otherwise SEL=0.
  - WAIT_BUSY:
    - CMD_BUSY=1 → RUN.
    - TIMEOUT cycles without CMD_BUSY → set TIMEOUT_ERR, go IDLE (SEL→0).
  - RUN: on CMD_BUSY=0 → VETO if SEL==AZ and VETO_LEN!=0, else IDLE.
  - VETO: counts VETO_LEN cycles, then IDLE.
- Latency: request pulse sampled at edge k with FSM idle and core not busy → START high in cycle after edge k+1 (one registered stage). SEL valid from START cycle until return to IDLE.
- AZ_VETO_FLAG: 1 from the AZ START cycle through RUN and VETO; 0 otherwise.
- Trigger drop rules; TRIG_DROP_CNT++ (saturate at 2^CNT_W-1) when TRIG_REQ=1 and any of:
  - AZ_VETO_FLAG=1,
  - trig_p already 1 and not being granted that cycle,
  - ENABLE=0.
  Dropped triggers never set trig_p.
- Simultaneous trigger request and trig_p grant in the same cycle: new trigger latched (trig_p stays 1), not dropped.
- SW_REQ/AZ while the corresponding flag is already pending: merged silently, not counted.
- CNT_CLR together with a drop event: clear wins, counter = 0.
- ENABLE falling:
  - All pending flags cleared, AZ timer held at 0.
  - An in-flight sequence runs to completion (WAIT_BUSY/RUN/VETO proceed).
  - No new START issued.
- CMD_BUSY already 1 in IDLE (foreign launch): no grant until it falls.

Decomposition:
- Shared package cmd_pkg:
  - SEL encodings SEL_NONE/SEL_TRIG/SEL_AZ/SEL_SW,
  - FSM state enum,
  - default TIMEOUT.
- One natural sub-module: cmd_sched_az_timer (AZ period counter plus az_p request output).
- Arbitration, FSM and drop counter stay in cmd_sched.

Test Plan:
- Single SW_REQ at cycle 10, CMD_BUSY model rises 3 cycles after START, lasts 20 → START at 12, SEL=3 from 12 until BUSY falls, no veto.
- TRIG_REQ and SW_REQ same cycle → trigger granted first (SEL=1); SW granted on next IDLE (SEL=3); TRIG_DROP_CNT=0.
- AZ_PERIOD=100, VETO_LEN=8; TRIG_REQ during AZ run and 5 cycles after BUSY falls → both dropped, count=2; trigger 9 cycles after BUSY falls → accepted.
- Three TRIG_REQ pulses while core busy on SW sequence → first pending, next two dropped (count=2); exactly one trigger launch follows.
- CMD_BUSY never rises after START, TIMEOUT=64 → TIMEOUT_ERR=1 at START+64, FSM IDLE; CNT_CLR clears it.
- Assert CMD_RST_N=0 mid-RUN → START/SEL/flag/counter immediately 0; after release, no spurious START without a new request.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared definitions for the command scheduler: sequence-select encodings,
// FSM state type and the default launch timeout.
package cmd_pkg;

    // Sequence select presented to cmd_core alongside START
    typedef logic [1:0] sel_t;

    localparam sel_t SEL_NONE = 2'd0;
    localparam sel_t SEL_TRIG = 2'd1;
    localparam sel_t SEL_AZ   = 2'd2;
    localparam sel_t SEL_SW   = 2'd3;

    // Cycles allowed between START and the core raising CMD_BUSY
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_RUN       = 2'd2,
        ST_VETO      = 2'd3
    } state_t;

endpackage

// File: rtl/cmd_sched_az_timer.sv
// Periodic auto-zero request generator. Counts enabled cycles and raises a
// 1-deep pending flag every period_i cycles; the flag is cleared when the
// scheduler grants the AZ sequence.
module cmd_sched_az_timer
    import cmd_pkg::*;
#(
    parameter int AZ_W = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            enable_i,
    input  logic [AZ_W-1:0] period_i,
    input  logic            grant_i,
    output logic            az_p_o
);

    logic [AZ_W-1:0] tmr_q, tmr_d;
    logic            az_p_q, az_p_d;
    logic            tick;

    // Period counter; a compare at or beyond period-1 also catches a period
    // that was lowered below the current count, so the new value takes
    // effect at the next compare without waiting for a full wrap.
    always_comb begin
        tmr_d = tmr_q;
        tick  = 1'b0;
        if (!enable_i) begin
            tmr_d = '0;
        end else if (period_i != '0) begin
            if (tmr_q >= (period_i - AZ_W'(1))) begin
                tick  = 1'b1;
                tmr_d = '0;
            end else begin
                tmr_d = tmr_q + AZ_W'(1);
            end
        end
    end

    // Pending flag: a fresh tick in the grant cycle keeps the request alive
    always_comb begin
        az_p_d = az_p_q;
        if (!enable_i) begin
            az_p_d = 1'b0;
        end else if (tick) begin
            az_p_d = 1'b1;
        end else if (grant_i) begin
            az_p_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmr_q  <= '0;
            az_p_q <= 1'b0;
        end else begin
            tmr_q  <= tmr_d;
            az_p_q <= az_p_d;
        end
    end

    assign az_p_o = az_p_q;

endmodule

// File: rtl/cmd_sched.sv
// Command scheduler: arbitrates trigger, auto-zero and software launch
// requests onto cmd_core, supervises each launch until the core goes idle,
// opens the trigger veto window around AZ sequences and counts dropped
// triggers.
module cmd_sched
    import cmd_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int AZ_W    = 16
) (
    input  logic             CMD_CLK,
    input  logic             CMD_RST_N,
    input  logic             ENABLE,
    input  logic [AZ_W-1:0]  AZ_PERIOD,
    input  logic [7:0]       VETO_LEN,
    input  logic             TRIG_REQ,
    input  logic             SW_REQ,
    input  logic             CMD_BUSY,
    input  logic             CNT_CLR,
    output logic             START,
    output logic [1:0]       SEL,
    output logic             AZ_VETO_FLAG,
    output logic             TIMEOUT_ERR,
    output logic [CNT_W-1:0] TRIG_DROP_CNT
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    // Saturating increment for the drop counter
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    state_t            state_q;
    logic              start_q;
    sel_t              sel_q;
    logic              veto_q;
    logic              tmo_q;
    logic [WCNT_W-1:0] wait_cnt_q;
    logic [7:0]        veto_cnt_q;

    logic              trig_p_q, trig_p_d;
    logic              sw_p_q, sw_p_d;
    logic              az_p;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic              can_grant;
    logic              grant_trig, grant_az, grant_sw, grant_any;
    logic              trig_drop;
    logic              timeout_hit;
    logic              veto_done;

    cmd_sched_az_timer #(
        .AZ_W (AZ_W)
    ) u_az_timer (
        .clk_i    (CMD_CLK),
        .rst_ni   (CMD_RST_N),
        .enable_i (ENABLE),
        .period_i (AZ_PERIOD),
        .grant_i  (grant_az),
        .az_p_o   (az_p)
    );

    // Fixed-priority arbitration (trig > AZ > SW), only from an idle core
    always_comb begin
        can_grant  = (state_q == ST_IDLE) && ENABLE && !CMD_BUSY;
        grant_trig = can_grant && trig_p_q;
        grant_az   = can_grant && !trig_p_q && az_p;
        grant_sw   = can_grant && !trig_p_q && !az_p && sw_p_q;
        grant_any  = grant_trig || grant_az || grant_sw;
    end

    // Launch supervision and veto window termination conditions
    always_comb begin
        timeout_hit = (state_q == ST_WAIT_BUSY) && !CMD_BUSY &&
                      (wait_cnt_q == WCNT_W'(TIMEOUT - 1));
        veto_done   = (({1'b0, veto_cnt_q} + 9'd1) >= {1'b0, VETO_LEN});
    end

    // Trigger acceptance: a trigger arriving while the pending one is being
    // granted is kept, so only an un-granted pending trigger causes a drop
    always_comb begin
        trig_drop = TRIG_REQ && (veto_q || (trig_p_q && !grant_trig) || !ENABLE);

        trig_p_d = trig_p_q;
        if (!ENABLE) begin
            trig_p_d = 1'b0;
        end else if (TRIG_REQ && !trig_drop) begin
            trig_p_d = 1'b1;
        end else if (grant_trig) begin
            trig_p_d = 1'b0;
        end

        sw_p_d = sw_p_q;
        if (!ENABLE) begin
            sw_p_d = 1'b0;
        end else if (SW_REQ) begin
            sw_p_d = 1'b1;
        end else if (grant_sw) begin
            sw_p_d = 1'b0;
        end

        drop_cnt_d = drop_cnt_q;
        if (CNT_CLR) begin
            drop_cnt_d = '0;
        end else if (trig_drop) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    // Pending request flags and dropped-trigger counter
    always_ff @(posedge CMD_CLK or negedge CMD_RST_N) begin
        if (!CMD_RST_N) begin
            trig_p_q   <= 1'b0;
            sw_p_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            trig_p_q   <= trig_p_d;
            sw_p_q     <= sw_p_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Launch sequencing FSM with registered START/SEL/veto/timeout outputs
    always_ff @(posedge CMD_CLK or negedge CMD_RST_N) begin
        if (!CMD_RST_N) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            sel_q      <= SEL_NONE;
            veto_q     <= 1'b0;
            tmo_q      <= 1'b0;
            wait_cnt_q <= '0;
            veto_cnt_q <= '0;
        end else begin
            start_q <= 1'b0;

            if (CNT_CLR) begin
                tmo_q <= 1'b0;
            end else if (timeout_hit) begin
                tmo_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (grant_any) begin
                        start_q    <= 1'b1;
                        wait_cnt_q <= '0;
                        veto_q     <= grant_az;
                        state_q    <= ST_WAIT_BUSY;
                        if (grant_trig) begin
                            sel_q <= SEL_TRIG;
                        end else if (grant_az) begin
                            sel_q <= SEL_AZ;
                        end else begin
                            sel_q <= SEL_SW;
                        end
                    end else begin
                        sel_q  <= SEL_NONE;
                        veto_q <= 1'b0;
                    end
                end

                ST_WAIT_BUSY: begin
                    if (CMD_BUSY) begin
                        state_q <= ST_RUN;
                    end else if (timeout_hit) begin
                        state_q <= ST_IDLE;
                        sel_q   <= SEL_NONE;
                        veto_q  <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
                    end
                end

                ST_RUN: begin
                    if (!CMD_BUSY) begin
                        if ((sel_q == SEL_AZ) && (VETO_LEN != 8'd0)) begin
                            veto_cnt_q <= '0;
                            state_q    <= ST_VETO;
                        end else begin
                            state_q <= ST_IDLE;
                            sel_q   <= SEL_NONE;
                            veto_q  <= 1'b0;
                        end
                    end
                end

                ST_VETO: begin
                    if (veto_done) begin
                        state_q <= ST_IDLE;
                        sel_q   <= SEL_NONE;
                        veto_q  <= 1'b0;
                    end else begin
                        veto_cnt_q <= veto_cnt_q + 8'd1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    sel_q   <= SEL_NONE;
                    veto_q  <= 1'b0;
                end
            endcase
        end
    end

    assign START         = start_q;
    assign SEL           = sel_q;
    assign AZ_VETO_FLAG  = veto_q;
    assign TIMEOUT_ERR   = tmo_q;
    assign TRIG_DROP_CNT = drop_cnt_q;

endmodule
